// File: rtl/alarm_pkg.sv
// Shared alarm definitions: FSM state encoding, field limit and wrap helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam logic [5:0] MAX_MINSEC = 6'd59;

  // Advance a minutes/seconds field, wrapping 59 back to 0.
  function automatic logic [5:0] inc_minsec(input logic [5:0] v);
    return (v >= MAX_MINSEC) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/alarm_ctrl_beep_gen.sv
// Buzzer square wave: high for HALF cycles, low for HALF cycles while enabled.
// Latency: output follows enable in the same cycle; the first half-period is high.
// Backpressure: none; the phase restarts every time enable goes low.
module beep_gen #(
  parameter int HALF = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic buzz
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] half_cnt;
  // 'quiet' is the inverted phase so every register resets to zero.
  logic          quiet;

  // Half-period counter and phase; held cleared while disabled so a new
  // enable always starts with a full high half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      quiet    <= 1'b0;
    end else if (!enable) begin
      half_cnt <= '0;
      quiet    <= 1'b0;
    end else if (half_cnt == LAST) begin
      half_cnt <= '0;
      quiet    <= ~quiet;
    end else begin
      half_cnt <= half_cnt + CW'(1);
    end
  end

  assign buzz = enable & ~quiet;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: stored alarm time, ring/snooze FSM, buzzer drive.
// Latency: o_ringing rises one cycle after the matching time appears.
// Backpressure: none; pulse inputs act in the cycle they are high.
// Optional snooze support is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int BEEP_HALF  = 12500000,
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_SEC = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic       i_alarm_en,
  input  logic       i_set_sec,
  input  logic       i_set_min,
  input  logic       i_stop,
  input  logic       i_snooze,
  output logic [5:0] o_alarm_sec,
  output logic [5:0] o_alarm_min,
  output logic       o_ringing,
  output logic       o_buzz
);

  state_t     state;
  logic [5:0] prev_sec;
  logic [5:0] prev_min;
  logic [5:0] tick_cnt;
  logic [5:0] tick_next;
  logic       tick;
  logic       match;

  // A new second shows up as any change of the seconds field.
  assign tick      = (i_sec != prev_sec);
  assign tick_next = tick_cnt + 6'd1;

  // Match fires only on the cycle the matching time first appears.
  assign match = i_alarm_en
               && ({i_min, i_sec} == {o_alarm_min, o_alarm_sec})
               && ({i_min, i_sec} != {prev_min, prev_sec});

  // Remember last cycle's time for tick and edge-of-match detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sec <= 6'd0;
      prev_min <= 6'd0;
    end else begin
      prev_sec <= i_sec;
      prev_min <= i_min;
    end
  end

  // Alarm time setting; frozen while ringing so the display cannot move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_alarm_sec <= 6'd0;
      o_alarm_min <= 6'd0;
    end else if (state != RING) begin
      if (i_set_sec) o_alarm_sec <= inc_minsec(o_alarm_sec);
      if (i_set_min) o_alarm_min <= inc_minsec(o_alarm_min);
    end
  end

  // Ring/snooze state machine with a shared tick counter and registered o_ringing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= 6'd0;
      o_ringing <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            state     <= RING;
            tick_cnt  <= 6'd0;
            o_ringing <= 1'b1;
          end
        end
        RING: begin
          if (i_stop || !i_alarm_en) begin
            state     <= IDLE;
            tick_cnt  <= 6'd0;
            o_ringing <= 1'b0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (i_snooze) begin
            state     <= SNOOZE;
            tick_cnt  <= 6'd0;
            o_ringing <= 1'b0;
          end
`endif
          else if (tick) begin
            if (tick_next == 6'(RING_SEC)) begin
              state     <= IDLE;
              tick_cnt  <= 6'd0;
              o_ringing <= 1'b0;
            end else begin
              tick_cnt <= tick_next;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (i_stop || !i_alarm_en) begin
            state     <= IDLE;
            tick_cnt  <= 6'd0;
            o_ringing <= 1'b0;
          end else if (tick) begin
            if (tick_next == 6'(SNOOZE_SEC)) begin
              state     <= RING;
              tick_cnt  <= 6'd0;
              o_ringing <= 1'b1;
            end else begin
              tick_cnt <= tick_next;
            end
          end
        end
`endif
        default: begin
          state     <= IDLE;
          tick_cnt  <= 6'd0;
          o_ringing <= 1'b0;
        end
      endcase
    end
  end

`ifndef ALARM_SNOOZE_EN
  // Snooze input and period have no function in this build.
  logic unused_snooze;
  assign unused_snooze = i_snooze | (SNOOZE_SEC == 0);
`endif

  // Buzzer runs only while ringing; o_ringing mirrors the RING state.
  beep_gen #(
    .HALF(BEEP_HALF)
  ) u_beep (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(o_ringing),
    .buzz  (o_buzz)
  );

endmodule

// File: tb/tb_alarm_ctrl.sv
`timescale 1ns/1ps
module tb_alarm_ctrl;

  localparam int BEEP_HALF  = 4;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_SEC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] i_sec = 6'd0;
  logic [5:0] i_min = 6'd0;
  logic       i_alarm_en = 1'b0;
  logic       i_set_sec = 1'b0;
  logic       i_set_min = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_snooze = 1'b0;
  logic [5:0] o_alarm_sec;
  logic [5:0] o_alarm_min;
  logic       o_ringing;
  logic       o_buzz;

  always #5 clk = ~clk;

  alarm_ctrl #(
    .BEEP_HALF (BEEP_HALF),
    .RING_SEC  (RING_SEC),
    .SNOOZE_SEC(SNOOZE_SEC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sec      (i_sec),
    .i_min      (i_min),
    .i_alarm_en (i_alarm_en),
    .i_set_sec  (i_set_sec),
    .i_set_min  (i_set_min),
    .i_stop     (i_stop),
    .i_snooze   (i_snooze),
    .o_alarm_sec(o_alarm_sec),
    .o_alarm_min(o_alarm_min),
    .o_ringing  (o_ringing),
    .o_buzz     (o_buzz)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 = quiet, 1 = ringing, 2 = snoozing.
  int m_mode;
  int m_asec, m_amin;
  int m_psec, m_pmin;
  int m_ticks;
  int m_ring_cyc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_asec = 0; m_amin = 0; m_psec = 0; m_pmin = 0;
    m_ticks = 0; m_ring_cyc = 0;
  endtask

  // One clock of the alarm rules, using the inputs present at the edge.
  task automatic model_update();
    bit tick;
    bit match;
    int old_mode;
    old_mode = m_mode;
    tick  = (int'(i_sec) != m_psec);
    match = i_alarm_en && int'(i_sec) == m_asec && int'(i_min) == m_amin
            && (int'(i_sec) != m_psec || int'(i_min) != m_pmin);
    case (old_mode)
      0: if (match) begin m_mode = 1; m_ticks = 0; m_ring_cyc = 0; end
      1: begin
        m_ring_cyc++;
        if (i_stop || !i_alarm_en) m_mode = 0;
`ifdef ALARM_SNOOZE_EN
        else if (i_snooze) begin m_mode = 2; m_ticks = 0; end
`endif
        else if (tick) begin
          m_ticks++;
          if (m_ticks >= RING_SEC) m_mode = 0;
        end
      end
      default: begin
        if (i_stop || !i_alarm_en) m_mode = 0;
        else if (tick) begin
          m_ticks++;
          if (m_ticks >= SNOOZE_SEC) begin m_mode = 1; m_ticks = 0; m_ring_cyc = 0; end
        end
      end
    endcase
    if (old_mode != 1) begin
      if (i_set_sec) m_asec = (m_asec + 1) % 60;
      if (i_set_min) m_amin = (m_amin + 1) % 60;
    end
    m_psec = int'(i_sec);
    m_pmin = int'(i_min);
  endtask

  task automatic compare_all();
    bit exp_buzz;
    exp_buzz = (m_mode == 1) && (((m_ring_cyc / BEEP_HALF) % 2) == 0);
    check("ringing", 32'(o_ringing), 32'(m_mode == 1));
    check("buzz", 32'(o_buzz), 32'(exp_buzz));
    check("alarm_sec", 32'(o_alarm_sec), 32'(m_asec));
    check("alarm_min", 32'(o_alarm_min), 32'(m_amin));
  endtask

  // Advance one clock, update the model, compare, then drop any pulses.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    i_set_sec = 1'b0; i_set_min = 1'b0; i_stop = 1'b0; i_snooze = 1'b0;
  endtask

  task automatic set_time(input int mm, input int ss);
    i_min = 6'(mm);
    i_sec = 6'(ss);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ring"}, 32'(o_ringing), 32'd0);
    check({tag, "_buzz"}, 32'(o_buzz), 32'd0);
    check({tag, "_asec"}, 32'(o_alarm_sec), 32'd0);
    check({tag, "_amin"}, 32'(o_alarm_min), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int r, k, tot;
    // Reset state, checked before any clock edge.
    #1;
    check_reset_outputs("por");
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 00:00 with alarm 00:00 right after reset must not trigger.
    i_alarm_en = 1'b1;
    step(); step();
    check("no_trig_00_00", 32'(o_ringing), 32'd0);

    // Alarm to 04:02, then time walks up to it.
    repeat (4) begin i_set_min = 1'b1; step(); end
    repeat (2) begin i_set_sec = 1'b1; step(); end
    check("set_min_4", 32'(o_alarm_min), 32'd4);
    check("set_sec_2", 32'(o_alarm_sec), 32'd2);
    set_time(3, 59); step(); step();
    set_time(4, 0);  step(); step();
    set_time(4, 1);  step(); step();
    set_time(4, 2);  step();
    check("ring_rise", 32'(o_ringing), 32'd1);
    check("buzz_c0", 32'(o_buzz), 32'd1);
    for (int c = 1; c < 9; c++) begin
      step();
      check($sformatf("buzz_c%0d", c), 32'(o_buzz), 32'((c % 8) < 4));
    end

    // Three second ticks end the ring.
    set_time(4, 3); step(); step();
    set_time(4, 4); step(); step();
    check("still_ring_2tick", 32'(o_ringing), 32'd1);
    set_time(4, 5); step();
    check("auto_stop", 32'(o_ringing), 32'd0);
    check("auto_stop_buzz", 32'(o_buzz), 32'd0);

    // Stop and snooze together: stop wins.
    set_time(4, 1); step();
    set_time(4, 2); step();
    check("ring_again", 32'(o_ringing), 32'd1);
    i_stop = 1'b1; i_snooze = 1'b1; step();
    check("stop_wins", 32'(o_ringing), 32'd0);

    // Snooze alone.
    set_time(4, 1); step();
    set_time(4, 2); step();
    i_snooze = 1'b1; step();
`ifdef ALARM_SNOOZE_EN
    check("snooze_quiet", 32'(o_ringing), 32'd0);
    check("snooze_buzz", 32'(o_buzz), 32'd0);
    set_time(4, 3); step(); step();
    check("snooze_1tick", 32'(o_ringing), 32'd0);
    set_time(4, 4); step();
    check("snooze_rering", 32'(o_ringing), 32'd1);
    check("snooze_rering_buzz", 32'(o_buzz), 32'd1);
`else
    check("snooze_ignored", 32'(o_ringing), 32'd1);
`endif
    i_stop = 1'b1; step();
    check("stop", 32'(o_ringing), 32'd0);

    // Alarm disabled while time passes the alarm value.
    i_alarm_en = 1'b0;
    set_time(4, 1); step();
    set_time(4, 2); step();
    set_time(4, 3); step();
    check("disabled_no_ring", 32'(o_ringing), 32'd0);
    i_alarm_en = 1'b1;

    // Drive alarm to 59:59 and check wrap of both fields.
    while (m_amin != 59) begin i_set_min = 1'b1; step(); end
    while (m_asec != 59) begin i_set_sec = 1'b1; step(); end
    check("at_59_59_sec", 32'(o_alarm_sec), 32'd59);
    i_set_sec = 1'b1; step();
    check("sec_wrap0", 32'(o_alarm_sec), 32'd0);
    repeat (59) begin i_set_sec = 1'b1; step(); end
    check("sec_back59", 32'(o_alarm_sec), 32'd59);
    i_set_min = 1'b1; step();
    check("min_wrap0", 32'(o_alarm_min), 32'd0);
    repeat (59) begin i_set_min = 1'b1; step(); end
    check("min_back59", 32'(o_alarm_min), 32'd59);

    // Set pulses are ignored while ringing.
    set_time(59, 58); step();
    set_time(59, 59); step();
    check("ring_59_59", 32'(o_ringing), 32'd1);
    i_set_sec = 1'b1; i_set_min = 1'b1; step();
    check("ring_hold_sec", 32'(o_alarm_sec), 32'd59);
    check("ring_hold_min", 32'(o_alarm_min), 32'd59);

    // Asynchronous reset mid-ring, then time held: no re-ring.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(); step(); step();
    check("no_rering", 32'(o_ringing), 32'd0);

    // Randomized traffic, biased to land on the alarm time often.
    i_alarm_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 25) begin
        if (i_sec == 6'd59) begin
          i_sec = 6'd0;
          i_min = (i_min == 6'd59) ? 6'd0 : i_min + 6'd1;
        end else begin
          i_sec = i_sec + 6'd1;
        end
      end else if (r < 30) begin
        k   = $urandom_range(0, 2);
        tot = m_amin * 60 + m_asec - k;
        if (tot < 0) tot += 3600;
        set_time(tot / 60, tot % 60);
      end
      i_set_sec = ($urandom_range(0, 49) == 0);
      i_set_min = ($urandom_range(0, 99) == 0);
      i_stop    = ($urandom_range(0, 59) == 0);
      i_snooze  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) i_alarm_en = ~i_alarm_en;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter BEEP_HALF, default 12500000: clk cycles per buzzer half-period (2 Hz beep at 50 MHz).
REQ-002 Parameter RING_SEC, default 30: seconds of ringing before auto-stop.
REQ-003 Parameter SNOOZE_SEC, default 10: seconds of silence per snooze.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_sec  input  6  current clock seconds, 0..59, synchronous to clk.
REQ-007 i_min  input  6  current clock minutes, 0..59, synchronous to clk.
REQ-008 i_alarm_en  input  1  level; alarm armed when 1.
REQ-009 i_set_sec  input  1  single-cycle pulse; increment alarm seconds.
REQ-010 i_set_min  input  1  single-cycle pulse; increment alarm minutes.
REQ-011 i_stop  input  1  single-cycle pulse; silence the alarm.
REQ-012 i_snooze  input  1  single-cycle pulse; snooze request.
REQ-013 o_alarm_sec  output  6  stored alarm seconds, for display.
REQ-014 o_alarm_min  output  6  stored alarm minutes, for display.
REQ-015 o_ringing  output  1  1 while in RING state.
REQ-016 o_buzz  output  1  square-wave buzzer drive.

Function
REQ-017 FSM states: IDLE, RING, SNOOZE; all transitions on posedge clk.
REQ-018 Match = i_alarm_en & {i_min,i_sec}=={o_alarm_min,o_alarm_sec} & {i_min,i_sec} differs from its value registered one cycle earlier, so each matching second triggers once.
REQ-019 IDLE -> RING the cycle after match; o_ringing rises one cycle after the matching time appears.
REQ-020 A second tick is any cycle where i_sec differs from its registered previous value; RING and SNOOZE count ticks in one 6-bit counter, cleared on every state entry.
REQ-021 RING -> IDLE on i_stop, on i_alarm_en=0, or when the tick count reaches RING_SEC.
REQ-022 o_buzz = 0 outside RING; on RING entry the half-period counter clears, o_buzz starts at 1, toggles every BEEP_HALF cycles.
REQ-023 i_set_sec/i_set_min increment the field modulo 60 (59 -> 0) in IDLE and SNOOZE; ignored in RING.
REQ-024 i_stop and i_snooze in the same cycle: i_stop wins.
REQ-025 Set pulse and match in the same cycle: match uses the pre-increment alarm value.
REQ-026 i_stop, i_snooze and set pulses in IDLE with no match: no state change apart from REQ-023.

Reset
REQ-027 rst_n low forces state IDLE, o_alarm_sec=0, o_alarm_min=0, o_ringing=0, o_buzz=0, all counters and previous-value registers 0, immediately and independent of clk.
REQ-028 Reset asserted mid-RING or mid-SNOOZE aborts to IDLE; no ring resumes after release until a new match.
REQ-029 Previous-value registers reset to 0, so time 00:00 with alarm 00:00 does not trigger in the first cycle after reset.

Configuration
REQ-030 Macro ALARM_SNOOZE_EN defined: RING -> SNOOZE on i_snooze; SNOOZE -> RING when the tick count reaches SNOOZE_SEC; SNOOZE -> IDLE on i_stop or i_alarm_en=0.
REQ-031 Macro undefined: SNOOZE state and its logic are absent; i_snooze is ignored; port list is unchanged.

Structure
REQ-032 Shared package alarm_pkg holds the state encoding (IDLE=2'd0, RING=2'd1, SNOOZE=2'd2) and constant MAX_MINSEC=6'd59.
REQ-033 Sub-module beep_gen (clk, rst_n, enable, half-period parameter -> square wave) produces o_buzz; all other logic sits in alarm_ctrl.

Verification (BEEP_HALF=4, RING_SEC=3, SNOOZE_SEC=2)
REQ-034 Four i_set_min and two i_set_sec pulses, then time steps 03:59 -> 04:02, i_alarm_en=1 -> o_ringing=1 one cycle after 04:02 appears; o_buzz 1 for 4 cycles, then 0 for 4 cycles.
REQ-035 Ringing, then three i_sec changes -> o_ringing=0 on the cycle after the third tick; o_buzz=0.
REQ-036 Alarm 59:59, 60 i_set_sec pulses -> o_alarm_sec returns to 0 then advances back to 59; RING hold plus set pulse -> value unchanged.
REQ-037 Ringing with i_stop and i_snooze in the same cycle -> IDLE; with the macro, i_snooze alone -> SNOOZE, o_buzz=0, RING again after 2 ticks.
REQ-038 rst_n pulsed low mid-RING -> all outputs 0 asynchronously; time held at alarm value -> no re-ring.
REQ-039 i_alarm_en=0 while time passes the alarm value -> o_ringing stays 0.
